// File: rtl/spi_rx_pkg.sv
// -----------------------------------------------------------------------------
// spi_rx_pkg
// Shared definitions for the SPI MISO receiver slice.
//   - RX_WORD_W_DEFAULT : default frame width in bits
//   - ST_IDLE / ST_SHIFT: raw state encodings (legacy-compatible constants)
//   - rx_state_t        : receiver FSM state type built on those encodings
//   - cnt_w()           : width of the bit counter for a given frame width
// -----------------------------------------------------------------------------
package spi_rx_pkg;

  localparam int RX_WORD_W_DEFAULT = 16;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  typedef enum logic [0:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT
  } rx_state_t;

  // The counter only has to reach WORD_W-2, so $clog2(WORD_W) bits suffice.
  // Clamped to 1 so a two-bit frame still gets a real (always-zero) counter.
  function automatic int cnt_w(input int word_w);
    return (word_w <= 2) ? 1 : $clog2(word_w);
  endfunction

endpackage

// File: rtl/spi_rx_holdreg.sv
// -----------------------------------------------------------------------------
// spi_rx_holdreg
// One-entry output register with a valid/ready handshake.
// Handshake: a word transfers to the consumer on every clock edge where
// o_valid and i_ready are both 1; i_ready is ignored while o_valid is 0.
// A load that arrives while the entry is full and not being drained is
// dropped and reported on o_ovr_set for that cycle.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_load       : a completed word is offered this cycle
//   i_data       : the offered word
//   i_ready      : consumer accepts o_word this cycle
//   o_word       : held word (keeps last value after being consumed)
//   o_valid      : entry full
//   o_ovr_set    : one-cycle strobe, offered word dropped
// -----------------------------------------------------------------------------
module spi_rx_holdreg #(
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_data,
  input  logic              i_ready,
  output logic [WORD_W-1:0] o_word,
  output logic              o_valid,
  output logic              o_ovr_set
);

  logic [WORD_W-1:0] r_word;
  logic              r_valid;
  logic              w_accept;

  // The entry can take a new word when empty or when it drains this edge.
  assign w_accept  = i_load & (~r_valid | i_ready);
  assign o_ovr_set = i_load & r_valid & ~i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_word  <= i_data;
        r_valid <= 1'b1;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_word  = r_word;
  assign o_valid = r_valid;

endmodule

// File: rtl/spi_miso_receiver.sv
// -----------------------------------------------------------------------------
// spi_miso_receiver
// Deserialises an MSB-first MISO stream into WORD_W-bit words. A frame starts
// on the cycle frame_start is high (that cycle carries the MSB) and completes
// WORD_W-1 cycles later. Completed words go to a one-entry valid/ready holding
// register; dropped words and mid-frame restarts raise sticky status bits.
// Ports:
//   sclk         : clock, everything sampled on the rising edge
//   rst          : asynchronous active-low reset
//   frame_start  : one-cycle frame pulse, marks the MSB cycle
//   serial_MISO  : serial data in
//   word_out     : received word, stable while word_valid is 1
//   word_valid   : holding register full
//   word_ready   : consumer accepts word_out when word_valid is 1
//   busy         : a frame is being shifted in
//   overrun      : sticky, a completed word was dropped
//   frame_err    : sticky, frame_start seen mid-frame
//   clr_status   : synchronous clear of overrun and frame_err
//   dbg_state    : current receiver FSM state
// -----------------------------------------------------------------------------
module spi_miso_receiver
  import spi_rx_pkg::*;
#(
  parameter int WORD_W = RX_WORD_W_DEFAULT
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              serial_MISO,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              busy,
  output logic              overrun,
  output logic              frame_err,
  input  logic              clr_status,
  output rx_state_t         dbg_state
);

  localparam int CNT_W = cnt_w(WORD_W);

  rx_state_t         r_state;
  logic [CNT_W-1:0]  r_bit_cnt;
  // Only WORD_W-1 bits are stored: the LSB is taken straight from the line
  // on the completing cycle.
  logic [WORD_W-2:0] r_shift;
  logic              r_overrun;
  logic              r_frame_err;

  rx_state_t         w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [WORD_W-2:0] w_shift_nxt;
  logic [WORD_W-1:0] w_word;
  logic              w_load;
  logic              w_ferr_set;
  logic              w_ovr_set;

  assign w_word = {r_shift, serial_MISO};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_load      = 1'b0;
    w_ferr_set  = 1'b0;
    case (r_state)
      IDLE: begin
        if (frame_start) begin
          // The MSB enters at the bottom and reaches the top after the
          // remaining WORD_W-1 shifts.
          w_shift_nxt = (WORD_W-1)'(serial_MISO);
          w_cnt_nxt   = CNT_W'(WORD_W - 2);
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (frame_start) begin
          // Restart: discard the partial word, this bit is the new MSB.
          w_ferr_set  = 1'b1;
          w_shift_nxt = (WORD_W-1)'(serial_MISO);
          w_cnt_nxt   = CNT_W'(WORD_W - 2);
        end else if (r_bit_cnt == '0) begin
          w_load      = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_shift_nxt = w_word[WORD_W-2:0];
          w_cnt_nxt   = r_bit_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_cnt_nxt;
      r_shift   <= w_shift_nxt;
      // A set event in the same cycle as clr_status wins.
      r_overrun   <= (r_overrun   & ~clr_status) | w_ovr_set;
      r_frame_err <= (r_frame_err & ~clr_status) | w_ferr_set;
    end
  end

  spi_rx_holdreg #(
    .WORD_W (WORD_W)
  ) u_holdreg (
    .clk       (sclk),
    .rst_n     (rst),
    .i_load    (w_load),
    .i_data    (w_word),
    .i_ready   (word_ready),
    .o_word    (word_out),
    .o_valid   (word_valid),
    .o_ovr_set (w_ovr_set)
  );

  assign busy      = (r_state == SHIFT);
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;
  assign dbg_state = r_state;

endmodule

// File: doc/spi_miso_receiver.md
# spi_miso_receiver

Receive-side counterpart of the `SPI_slave` serializer. Captures the serial `processed_MISO` stream MSB-first, starting on the slave's `Outdata_valid` frame pulse, and reassembles each frame into a parallel word. Completed words are held in a one-entry output register with a valid/ready handshake. Overrun and framing faults are reported as sticky status bits. Used wherever the FPGA itself must consume slave frames, including as the bench/loopback checker for the ADC driver path.

## Interface
Parameters:
- `WORD_W`, 16: bits per frame; must be ≥ 2.

Ports:
- `sclk`  in  1: single clock; all sampling on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `frame_start`  in  1: one-cycle frame pulse (connects to slave `Outdata_valid`); marks the cycle carrying the MSB.
- `serial_MISO`  in  1: serial data (connects to slave `processed_MISO`).
- `word_out`  out  WORD_W: received word; stable while `word_valid` = 1.
- `word_valid`  out  1: holding register full.
- `word_ready`  in  1: consumer accepts `word_out` on a cycle where `word_valid` = 1.
- `busy`  out  1: a frame is being shifted in.
- `overrun`  out  1: sticky; a completed frame was dropped because the holding register was full.
- `frame_err`  out  1: sticky; `frame_start` arrived mid-frame.
- `clr_status`  in  1: synchronous clear of `overrun` and `frame_err`.

## Operation
- FSM states: `IDLE`, `SHIFT`.
- `IDLE`:
  - If `frame_start` = 1, shift `serial_MISO` in as bit `WORD_W-1`, set `bit_cnt` = `WORD_W-2`, go to `SHIFT`.
  - Otherwise stay in `IDLE`.
- `SHIFT`:
  - Each cycle, shift `serial_MISO` in at the LSB (shift-left).
  - When `bit_cnt` = 0, that bit is the LSB and the frame is complete: go to `IDLE` and present the assembled word to the holding register.
  - Otherwise decrement `bit_cnt`.
- `frame_start` = 1 while in `SHIFT` (any bit position, including the LSB cycle):
  - Discard the partial word and set `frame_err`.
  - Restart capture in the same cycle: that cycle's bit becomes the MSB and `bit_cnt` = `WORD_W-2`.
- Holding register, on frame completion:
  - Empty, or being consumed this same cycle (`word_valid` & `word_ready`): load the new word; `word_valid` stays or becomes 1.
  - Full and not consumed: drop the new word, keep the old one, set `overrun`.
- Consumption with no new word arriving: `word_valid` falls to 0 on the next edge. `word_out` keeps its last value.
- Status bits:
  - `clr_status` clears `overrun` and `frame_err`.
  - A set event in the same cycle as `clr_status` wins; the bit stays 1.
- `busy` = (state == `SHIFT`), registered.
- Reset values (asserting `rst` low at any time, including mid-frame): state `IDLE`, `bit_cnt` = 0, shift register = 0, `word_out` = 0, `word_valid` = 0, `busy` = 0, `overrun` = 0, `frame_err` = 0. A partial frame is discarded with no error flagged.

## Timing
- Frame pulse at edge N: MSB sampled at N, bits `WORD_W-2`..0 at N+1..N+`WORD_W`-1.
- `word_valid` and `word_out` update at edge N+`WORD_W`-1, visible from cycle N+`WORD_W`.
- Latency from frame pulse to data: `WORD_W` cycles.
- Back-to-back frames: the next `frame_start` is legal at cycle N+`WORD_W`, giving zero idle cycles and full throughput.
- `frame_start` at N+`WORD_W`-1 is mid-frame and is handled as a framing error.
- Handshake: transfer on the edge where `word_valid` & `word_ready`. Deasserting `word_valid` requires no consumer action beyond `word_ready`. `word_ready` while `word_valid` = 0 is ignored.
- All outputs are registered; there is no combinational path from any input to any output.

## Structure
- Package `spi_rx_pkg`:
  - `rx_state_t` enum {`IDLE`, `SHIFT`}.
  - `localparam` default `WORD_W` = 16.
  - Counter width function `$clog2(WORD_W)`.
- Sub-module `spi_rx_holdreg`: one-entry valid/ready holding register plus overrun detection. Inputs: load strobe and data. Outputs: `word_out`, `word_valid`, overrun-set strobe.
- Top level contains the FSM, `bit_cnt`, shift register and sticky status logic.

## Test plan
- Reset: hold `rst` = 0 for 2 cycles, then release → every output is 0. Release `rst` mid-frame → partial word discarded, `frame_err` = 0.
- Single frame: `frame_start` at N, serial bits 16'hAAAB MSB-first, `word_ready` = 1 → `word_out` = 16'hAAAB and `word_valid` = 1 at N+16 for exactly one cycle; `busy` = 1 for cycles N+1..N+15.
- Back-to-back with stall: frames 16'hAAAB then 16'h5AAE with zero gap, `word_ready` = 0 → `word_out` stays 16'hAAAB and `overrun` = 1 from N+32. Then `clr_status` → `overrun` = 0.
- Simultaneous consume and load: second frame completes on the same edge `word_ready` = 1 accepts the first word → `word_out` = 16'h5AAE, `word_valid` continuously 1, `overrun` = 0.
- Framing error: `frame_start` at bit 8 of a frame, then a full 16'h1234 frame from that pulse → `frame_err` = 1, `word_out` = 16'h1234, partial word never presented.
- Clear/set collision: `clr_status` asserted on the same edge as an overrun event → `overrun` remains 1.
